// File: rtl/burst_detector.sv
// burst_detector: hysteresis burst detector for the RMS signal path.
// Consumes one RMS sample per in_valid. Reports registered start/end pulses,
// the active level, the last completed burst length and a saturating count.
// Optional macro BURST_DETECTOR_TIMEOUT_EN adds max_len / burst_timeout and a
// LOCKOUT state that force-ends over-long bursts.
module burst_detector #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned LEN_W  = 16,
   parameter int unsigned MIN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_rms_val,
   input  logic [DATA_W-1:0] thr_hi,
   input  logic [DATA_W-1:0] thr_lo,
   input  logic [MIN_W-1:0]  min_on,
   input  logic [MIN_W-1:0]  min_off,
   input  logic              clr_count,
   output logic              burst_active,
   output logic              burst_start,
   output logic              burst_end,
   output logic [LEN_W-1:0]  burst_len,
   output logic [CNT_W-1:0]  burst_counter
`ifdef BURST_DETECTOR_TIMEOUT_EN
   ,
   input  logic [LEN_W-1:0]  max_len,
   output logic              burst_timeout
`endif
);

`ifdef BURST_DETECTOR_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, ARMING, ACTIVE, RELEASING, LOCKOUT} state_t;
`else
   typedef enum logic [2:0] {IDLE, ARMING, ACTIVE, RELEASING} state_t;
`endif

   state_t             state, state_n;
   logic [MIN_W-1:0]   run, run_n;
   logic [MIN_W-1:0]   off_run, off_n;
   logic [LEN_W-1:0]   acc, acc_n, acc_inc;
   logic [LEN_W-1:0]   len_n, end_len;
   logic [CNT_W-1:0]   cnt_n;
   logic [MIN_W-1:0]   eff_on, eff_off;
   logic [MIN_W:0]     run_inc, off_inc;
   logic               qual, low;
   logic               confirm, finish, active_n;
`ifdef BURST_DETECTOR_TIMEOUT_EN
   logic               timeout_n;
`endif

   assign qual    = in_rms_val > thr_hi;
   assign low     = in_rms_val <= thr_lo;
   assign eff_on  = (min_on  == '0) ? MIN_W'(1) : min_on;
   assign eff_off = (min_off == '0) ? MIN_W'(1) : min_off;
   assign run_inc = {1'b0, run}     + (MIN_W+1)'(1);
   assign off_inc = {1'b0, off_run} + (MIN_W+1)'(1);
   assign acc_inc = (acc == '1) ? acc : acc + LEN_W'(1);
   // A saturated accumulator means the true length is unknown: report all-ones.
   assign end_len = (acc_inc == '1) ? '1 : acc_inc - LEN_W'(eff_off);

   // Next-state, run counters, accumulator and next output values.
   always_comb begin
      state_n  = state;
      run_n    = run;
      off_n    = off_run;
      acc_n    = acc;
      len_n    = burst_len;
      confirm  = 1'b0;
      finish   = 1'b0;
`ifdef BURST_DETECTOR_TIMEOUT_EN
      timeout_n = 1'b0;
`endif
      if (in_valid) begin
         case (state)
            IDLE: begin
               if (qual) begin
                  run_n = MIN_W'(1);
                  acc_n = LEN_W'(1);
                  if (eff_on == MIN_W'(1)) begin
                     state_n = ACTIVE;
                     confirm = 1'b1;
                  end else begin
                     state_n = ARMING;
                  end
               end
            end
            ARMING: begin
               if (qual) begin
                  run_n = run_inc[MIN_W-1:0];
                  acc_n = acc_inc;
                  if (run_inc >= {1'b0, eff_on}) begin
                     state_n = ACTIVE;
                     confirm = 1'b1;
                  end
               end else begin
                  state_n = IDLE;
                  run_n   = '0;
                  acc_n   = '0;
               end
            end
            ACTIVE: begin
               acc_n = acc_inc;
               if (low) begin
                  if (eff_off == MIN_W'(1)) begin
                     finish = 1'b1;
                  end else begin
                     off_n   = MIN_W'(1);
                     state_n = RELEASING;
                  end
               end
            end
            RELEASING: begin
               acc_n = acc_inc;
               if (low) begin
                  if (off_inc >= {1'b0, eff_off}) begin
                     finish = 1'b1;
                  end else begin
                     off_n = off_inc[MIN_W-1:0];
                  end
               end else begin
                  state_n = ACTIVE;
                  off_n   = '0;
               end
            end
`ifdef BURST_DETECTOR_TIMEOUT_EN
            LOCKOUT: begin
               if (low) begin
                  state_n = IDLE;
               end
            end
`endif
            default: state_n = IDLE;
         endcase

         if (finish) begin
            state_n = IDLE;
            run_n   = '0;
            off_n   = '0;
            acc_n   = '0;
            len_n   = end_len;
         end

`ifdef BURST_DETECTOR_TIMEOUT_EN
         // Force-end overrides a normal end landing on the same sample.
         if ((state == ACTIVE || state == RELEASING) &&
             (max_len != '0) && (acc_inc >= max_len)) begin
            state_n   = LOCKOUT;
            run_n     = '0;
            off_n     = '0;
            acc_n     = '0;
            finish    = 1'b1;
            timeout_n = 1'b1;
            len_n     = max_len;
         end
`endif
      end

      cnt_n = clr_count ? '0 : burst_counter;
      if (confirm && (cnt_n != '1)) begin
         cnt_n = cnt_n + CNT_W'(1);
      end
      active_n = (state_n == ACTIVE) || (state_n == RELEASING);
   end

   // State, counters and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         run           <= '0;
         off_run       <= '0;
         acc           <= '0;
         burst_active  <= 1'b0;
         burst_start   <= 1'b0;
         burst_end     <= 1'b0;
         burst_len     <= '0;
         burst_counter <= '0;
      end else begin
         state         <= state_n;
         run           <= run_n;
         off_run       <= off_n;
         acc           <= acc_n;
         burst_active  <= active_n;
         burst_start   <= confirm;
         burst_end     <= finish;
         burst_len     <= len_n;
         burst_counter <= cnt_n;
      end
   end

`ifdef BURST_DETECTOR_TIMEOUT_EN
   // Timeout pulse register.
   always_ff @(posedge clk) begin
      if (rst) begin
         burst_timeout <= 1'b0;
      end else begin
         burst_timeout <= timeout_n;
      end
   end
`endif

endmodule

// File: tb/tb_burst_detector.sv
// tb_burst_detector: directed self-checking bench for burst_detector.
// Uses CNT_W=2 so counter saturation is reachable; timeout scenario runs only
// when BURST_DETECTOR_TIMEOUT_EN is defined.
module tb_burst_detector;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned MIN_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [DATA_W-1:0] in_rms_val;
   logic [DATA_W-1:0] thr_hi;
   logic [DATA_W-1:0] thr_lo;
   logic [MIN_W-1:0]  min_on;
   logic [MIN_W-1:0]  min_off;
   logic              clr_count;
   logic              burst_active;
   logic              burst_start;
   logic              burst_end;
   logic [LEN_W-1:0]  burst_len;
   logic [CNT_W-1:0]  burst_counter;
`ifdef BURST_DETECTOR_TIMEOUT_EN
   logic [LEN_W-1:0]  max_len;
   logic              burst_timeout;
   logic              exp_to;
`endif

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned step_no = 0;

   burst_detector #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W),
      .LEN_W (LEN_W),
      .MIN_W (MIN_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_rms_val   (in_rms_val),
      .thr_hi       (thr_hi),
      .thr_lo       (thr_lo),
      .min_on       (min_on),
      .min_off      (min_off),
      .clr_count    (clr_count),
      .burst_active (burst_active),
      .burst_start  (burst_start),
      .burst_end    (burst_end),
      .burst_len    (burst_len),
      .burst_counter(burst_counter)
`ifdef BURST_DETECTOR_TIMEOUT_EN
      ,
      .max_len      (max_len),
      .burst_timeout(burst_timeout)
`endif
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s step %0d: observed %0d expected %0d", tag, step_no, obs, exp);
      end
   endtask

   // Apply one cycle of input, then check pulses and level after the edge.
   task automatic step(input logic v, input logic [DATA_W-1:0] s,
                       input logic es, input logic ee, input logic ea);
      in_valid   = v;
      in_rms_val = s;
      @(posedge clk);
      #1;
      step_no++;
      chk("burst_start",  {31'd0, burst_start},  {31'd0, es});
      chk("burst_end",    {31'd0, burst_end},    {31'd0, ee});
      chk("burst_active", {31'd0, burst_active}, {31'd0, ea});
`ifdef BURST_DETECTOR_TIMEOUT_EN
      chk("burst_timeout", {31'd0, burst_timeout}, {31'd0, exp_to});
`endif
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Directed scenario sequence.
   initial begin
      rst        = 1'b1;
      in_valid   = 1'b1;
      in_rms_val = 16'd200;
      thr_hi     = 16'd100;
      thr_lo     = 16'd50;
      min_on     = 8'd3;
      min_off    = 8'd2;
      clr_count  = 1'b0;
`ifdef BURST_DETECTOR_TIMEOUT_EN
      max_len    = '0;
      exp_to     = 1'b0;
`endif
      #2;

      // Reset held for two cycles with qualifying samples present.
      step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
      chk("reset_len", 32'(burst_len), 32'd0);
      chk("reset_cnt", 32'(burst_counter), 32'd0);
      rst = 1'b0;

      // Basic burst: acc reaches 6 at end, len = 6 - 2 = 4.
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd120, 1'b1, 1'b0, 1'b1);
      chk("basic_cnt", 32'(burst_counter), 32'd1);
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd40,  1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd40,  1'b0, 1'b1, 1'b0);
      chk("basic_len", 32'(burst_len), 32'd4);

      // Glitch rejection.
      do_reset();
      chk("clr_by_rst", 32'(burst_counter), 32'd0);
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd30,  1'b0, 1'b0, 1'b0);
      chk("glitch_cnt", 32'(burst_counter), 32'd0);

      // Stalls hold the run; stall inside RELEASING holds too. acc=5, len=3.
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'd0,   1'b0, 1'b0, 1'b0);
      step(1'b0, 16'd0,   1'b0, 1'b0, 1'b0);
      step(1'b0, 16'd0,   1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd120, 1'b1, 1'b0, 1'b1);
      chk("stall_cnt", 32'(burst_counter), 32'd1);
      step(1'b1, 16'd40,  1'b0, 1'b0, 1'b1);
      step(1'b0, 16'd40,  1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd40,  1'b0, 1'b1, 1'b0);
      chk("stall_len", 32'(burst_len), 32'd3);

      // Back-to-back hysteresis burst: acc=12, len=10.
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd120, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd120, 1'b1, 1'b0, 1'b1);
      chk("hyst_cnt", 32'(burst_counter), 32'd2);
      for (int i = 0; i < 5; i++) step(1'b1, 16'd80, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd40, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd90, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd40, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd40, 1'b0, 1'b1, 1'b0);
      chk("hyst_len", 32'(burst_len), 32'd10);
      chk("hyst_cnt2", 32'(burst_counter), 32'd2);

      // Threshold edges with min_on/min_off = 0 (treated as 1): acc=3, len=2.
      min_on  = 8'd0;
      min_off = 8'd0;
      step(1'b1, 16'd100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd101, 1'b1, 1'b0, 1'b1);
      chk("edge_cnt", 32'(burst_counter), 32'd3);
      step(1'b1, 16'd51,  1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd50,  1'b0, 1'b1, 1'b0);
      chk("edge_len", 32'(burst_len), 32'd2);

      // Fourth burst: counter saturates at 3; len = 2 - 1 = 1.
      step(1'b1, 16'd120, 1'b1, 1'b0, 1'b1);
      chk("sat_cnt", 32'(burst_counter), 32'd3);
      step(1'b1, 16'd40,  1'b0, 1'b1, 1'b0);
      chk("sat_len", 32'(burst_len), 32'd1);

      // Clear coincident with confirm yields 1; clear alone yields 0.
      clr_count = 1'b1;
      step(1'b1, 16'd120, 1'b1, 1'b0, 1'b1);
      chk("clr_confirm_cnt", 32'(burst_counter), 32'd1);
      clr_count = 1'b0;
      step(1'b1, 16'd40,  1'b0, 1'b1, 1'b0);
      clr_count = 1'b1;
      step(1'b0, 16'd0,   1'b0, 1'b0, 1'b0);
      chk("clr_cnt", 32'(burst_counter), 32'd0);
      clr_count = 1'b0;

      // Reset mid-burst: no end pulse.
      step(1'b1, 16'd120, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      step(1'b1, 16'd40,  1'b0, 1'b0, 1'b0);
      chk("midrst_cnt", 32'(burst_counter), 32'd0);
      chk("midrst_len", 32'(burst_len), 32'd0);
      rst = 1'b0;
      step(1'b1, 16'd40,  1'b0, 1'b0, 1'b0);
      min_on  = 8'd3;
      min_off = 8'd2;

`ifdef BURST_DETECTOR_TIMEOUT_EN
      // Timeout with max_len=5, then lockout until a low sample.
      do_reset();
      max_len = 16'd5;
      step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd200, 1'b1, 1'b0, 1'b1);
      step(1'b1, 16'd200, 1'b0, 1'b0, 1'b1);
      exp_to = 1'b1;
      step(1'b1, 16'd200, 1'b0, 1'b1, 1'b0);
      exp_to = 1'b0;
      chk("to_len", 32'(burst_len), 32'd5);
      for (int i = 0; i < 5; i++) step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd40,  1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd200, 1'b1, 1'b0, 1'b1);
      chk("to_cnt", 32'(burst_counter), 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/burst_detector.md
# burst_detector

Parametrised burst detector for the RMS signal path. It sits downstream of the RMS stage and consumes one RMS sample per `in_valid`. Hysteresis thresholds and minimum on/off durations reject glitches. It reports burst start/end pulses, the active level, the length of the last completed burst and a saturating burst count.

## Interface
- `DATA_W`, 16: width of the RMS sample and the thresholds.
- `CNT_W`, 8: width of the burst counter.
- `LEN_W`, 16: width of the burst-length accumulator and `burst_len`.
- `MIN_W`, 8: width of `min_on` and `min_off`.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_rms_val` carries a new sample this cycle.
- `in_rms_val`  in  DATA_W  unsigned RMS sample.
- `thr_hi`  in  DATA_W  entry threshold; a sample qualifies if strictly greater.
- `thr_lo`  in  DATA_W  exit threshold; a sample is low if less than or equal.
- `min_on`  in  MIN_W  consecutive qualifying samples needed to confirm a burst; 0 is treated as 1.
- `min_off`  in  MIN_W  consecutive low samples needed to end a burst; 0 is treated as 1.
- `clr_count`  in  1  synchronous clear of `burst_counter`.
- `burst_active`  out  1  high while in ACTIVE or RELEASING.
- `burst_start`  out  1  one-cycle pulse when a burst is confirmed.
- `burst_end`  out  1  one-cycle pulse when a burst ends.
- `burst_len`  out  LEN_W  length of the last completed burst, in samples.
- `burst_counter`  out  CNT_W  confirmed bursts since reset or clear; saturates.

## Operation
- FSM states: IDLE, ARMING, ACTIVE, RELEASING (plus LOCKOUT, see Configuration).
- The FSM advances only on `in_valid`. With `in_valid` low, all state, run counters and `acc` hold, and pulses are 0.
- `acc` counts every valid sample from the first qualifying sample onward. It saturates at all-ones.
- IDLE:
  - A qualifying sample starts a run: `run`=1, `acc`=1.
  - If effective `min_on`=1, go straight to ACTIVE (confirm). Otherwise go to ARMING.
- ARMING:
  - A qualifying sample increments `run`. When `run` reaches `min_on`, go to ACTIVE (confirm).
  - A non-qualifying sample returns to IDLE and clears `run` and `acc`.
- Confirm:
  - `burst_start`=1 for one cycle and `burst_active` goes to 1.
  - `burst_counter` increments, saturating at 2^CNT_W-1.
- ACTIVE:
  - A low sample sets `off_run`=1 and moves to RELEASING, or ends the burst immediately if `min_off`=1.
  - Any other sample stays in ACTIVE.
- RELEASING:
  - A low sample increments `off_run`. When `off_run` reaches `min_off`, the burst ends.
  - A sample greater than `thr_lo` returns to ACTIVE and clears `off_run`. The low samples already seen stay counted in `acc`.
- End of burst:
  - `burst_end`=1 for one cycle and `burst_active`=0.
  - `burst_len` = `acc` (including the current sample) minus effective `min_off`. If `acc` is saturated, `burst_len` is all-ones.
  - FSM returns to IDLE.
- `clr_count` zeroes `burst_counter`. If a confirm occurs in the same cycle, the counter becomes 1.
- If `thr_lo` > `thr_hi`, there is no special handling; the comparisons apply exactly as defined.
- Thresholds and minimums are sampled each cycle. Changing them mid-burst takes effect on the next valid sample.

## Timing
- All outputs are registered. A response appears on the edge that samples the causing input, i.e. one clock of latency.
- Reset values: FSM=IDLE; `burst_active`, `burst_start`, `burst_end`=0; `burst_len`=0; `burst_counter`=0; `run`, `off_run`, `acc`=0.
- Asserting `rst` mid-burst returns to IDLE on the next edge and does not produce a `burst_end` pulse.
- `burst_end` and `burst_active` falling occur on the same edge.
- Back-to-back bursts are allowed: a qualifying sample on the cycle after an end starts a new run in IDLE.

## Configuration
- Macro: `BURST_DETECTOR_TIMEOUT_EN`.
- Defined: adds input `max_len` (LEN_W) and output `burst_timeout` (1, reset 0).
  - In ACTIVE or RELEASING, when `acc` reaches a nonzero `max_len`, the burst is force-ended.
  - Force-end outputs: `burst_end`=1, `burst_timeout`=1 for one cycle, and `burst_len`=`max_len`.
  - The FSM then enters LOCKOUT. It stays there until a valid sample ≤ `thr_lo`, then goes to IDLE; that low sample does not start a run.
- Not defined: no `max_len` or `burst_timeout` ports, no LOCKOUT state, and bursts are unbounded.

## Test plan
Defaults for all scenarios: thr_hi=100, thr_lo=50, min_on=3, min_off=2, `in_valid`=1.

- Reset: hold `rst` for 2 cycles with samples of 200 applied -> all outputs 0, no pulses.
- Basic burst: samples 120,120,120,120,40,40 -> `burst_start` on the edge after the 3rd sample, `burst_counter`=1; `burst_end` after the 6th sample with `burst_len`=4.
- Glitch rejection and stalls: samples 120,120,30 -> no start, counter 0. Then 120, (`in_valid`=0 for 3 cycles), 120,120 -> start after the 3rd valid sample.
- Hysteresis: 120×3, 80×5, 40, 90, 40, 40 -> exactly one start and one end; `burst_len`=10.
- Saturation and clear with CNT_W=2: 4 bursts -> `burst_counter`=3. `clr_count` coincident with the next confirm -> counter=1.
- Timeout with the macro defined, `max_len`=5: 10 samples of 200 -> `burst_end` and `burst_timeout` after the 5th sample, `burst_len`=5. No new start until a sample of 40 is seen, then 200×3 -> start.
